// File: rtl/crossbar_ingress_queue.sv
// Per-port ingress FIFOs ahead of the crossbar; out-of-range destinations are dropped and counted.
// Latency: 1 cycle from accepted push to head presentation (no bypass). Pops happen on req & grant.
// Backpressure: in_ready[i] is low only while port i's FIFO is full; drops never stall the source.
module crossbar_ingress_queue #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int DW    = 32,
    parameter int DESTW = 2,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N-1:0]                     in_valid,
    output logic [N-1:0]                     in_ready,
    input  logic [N*DESTW-1:0]               in_dest,
    input  logic [N*DW-1:0]                  in_data,
    output logic [N-1:0]                     req,
    output logic [N*DESTW-1:0]               dest,
    output logic [N*DW-1:0]                  data_out,
    input  logic [N-1:0]                     grant,
    output logic [N*($clog2(DEPTH)+1)-1:0]   occupancy,
    output logic [15:0]                      drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int EW = DESTW + DW;

    logic [EW-1:0] mem_q    [N][DEPTH];
    logic [AW-1:0] wr_ptr_q [N];
    logic [AW-1:0] rd_ptr_q [N];
    logic [OW-1:0] occ_q    [N];
    logic [15:0]   drop_count_q;
    logic [15:0]   drop_count_d;
    logic [16:0]   drop_sum;

    logic [N-1:0]  dest_ok;
    logic [N-1:0]  push;
    logic [N-1:0]  drop;
    logic [N-1:0]  pop;
    logic [EW-1:0] head;

    always_comb begin
        in_ready  = '0;
        req       = '0;
        dest      = '0;
        data_out  = '0;
        occupancy = '0;
        dest_ok   = '0;
        push      = '0;
        drop      = '0;
        pop       = '0;
        head      = '0;
        drop_sum  = {1'b0, drop_count_q};
        for (int i = 0; i < N; i++) begin
            in_ready[i] = occ_q[i] < OW'(DEPTH);
            // Zero-extended compare stays correct when M == 2**DESTW (never drops).
            dest_ok[i]  = 32'(in_dest[i*DESTW +: DESTW]) < M;
            push[i]     = in_valid[i] & in_ready[i] & dest_ok[i];
            drop[i]     = in_valid[i] & in_ready[i] & ~dest_ok[i];
            req[i]      = occ_q[i] != '0;
            pop[i]      = req[i] & grant[i];
            head        = mem_q[i][rd_ptr_q[i]];
            if (req[i]) begin
                dest[i*DESTW +: DESTW] = head[DW +: DESTW];
                data_out[i*DW +: DW]   = head[DW-1:0];
            end
            occupancy[i*OW +: OW] = occ_q[i];
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign drop_count = drop_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   occ_q[i] <= occ_q[i] + 1'b1;
                    2'b01:   occ_q[i] <= occ_q[i] - 1'b1;
                    default: occ_q[i] <= occ_q[i];
                endcase
            end
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: empty FIFOs mask their contents on the outputs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {in_dest[i*DESTW +: DESTW], in_data[i*DW +: DW]};
            end
        end
    end

endmodule

// File: tb/tb_crossbar_ingress_queue.sv
// Bench for crossbar_ingress_queue built with M=3 so the drop path is reachable.
module tb_crossbar_ingress_queue;

    localparam int N     = 4;
    localparam int M     = 3;
    localparam int DW    = 32;
    localparam int DESTW = 2;
    localparam int DEPTH = 4;
    localparam int OW    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [N*DESTW-1:0]   in_dest;
    logic [N*DW-1:0]      in_data;
    logic [N-1:0]         req;
    logic [N*DESTW-1:0]   dest;
    logic [N*DW-1:0]      data_out;
    logic [N-1:0]         grant;
    logic [N*OW-1:0]      occupancy;
    logic [15:0]          drop_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [DESTW+DW-1:0] sb [N][$];
    int                  mdrop;

    crossbar_ingress_queue #(
        .N(N), .M(M), .DW(DW), .DESTW(DESTW), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dest    (in_dest),
        .in_data    (in_data),
        .req        (req),
        .dest       (dest),
        .data_out   (data_out),
        .grant      (grant),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_dest  = '0;
        in_data  = '0;
        grant    = '0;
    endtask

    task automatic drive(input int p, input logic [1:0] d, input logic [31:0] w);
        in_valid[p]           = 1'b1;
        in_dest[p*DESTW +: DESTW] = d;
        in_data[p*DW +: DW]   = w;
    endtask

    // Compare outputs to the model, then update the model with this cycle's stimulus and clock once.
    task automatic tick();
        logic do_pop;
        #1;
        for (int p = 0; p < N; p++) begin
            check("in_ready", in_ready[p], sb[p].size() < DEPTH);
            check("req", req[p], sb[p].size() != 0);
            check("occupancy", occupancy[p*OW +: OW], sb[p].size());
            if (sb[p].size() != 0) begin
                check("head_dest", dest[p*DESTW +: DESTW], sb[p][0][DW +: DESTW]);
                check("head_data", data_out[p*DW +: DW], sb[p][0][DW-1:0]);
            end else begin
                check("empty_dest", dest[p*DESTW +: DESTW], 0);
                check("empty_data", data_out[p*DW +: DW], 0);
            end
        end
        check("drop_count", drop_count, mdrop);
        for (int p = 0; p < N; p++) begin
            do_pop = grant[p] && sb[p].size() != 0;
            if (in_valid[p] && sb[p].size() < DEPTH) begin
                if (in_dest[p*DESTW +: DESTW] < M)
                    sb[p].push_back({in_dest[p*DESTW +: DESTW], in_data[p*DW +: DW]});
                else if (mdrop < 16'hFFFF)
                    mdrop++;
            end
            if (do_pop) void'(sb[p].pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        mdrop = 0;
        #2;
        check("rst_req", req, 0);
        check("rst_dest", dest, 0);
        check("rst_data", data_out, 0);
        check("rst_occ", occupancy, 0);
        check("rst_drops", drop_count, 0);
        check("rst_ready", in_ready, 4'b1111);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: single push, visible next cycle
        drive(0, 2'd0, 32'hA1A1A1A1);
        tick();
        idle_inputs();
        check("t1_req", req, 4'b0001);
        check("t1_data", data_out[31:0], 32'hA1A1A1A1);
        tick();

        // 2: fill port 1, reject a 5th push, then drain in order
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            drive(1, 2'd1, 32'hB0B0B0B0 + k);
            tick();
        end
        idle_inputs();
        check("t2_full", in_ready[1], 1'b0);
        grant[1] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        idle_inputs();
        check("t2_drained", req[1], 1'b0);

        // 3: push and pop on the same edge
        drive(2, 2'd2, 32'hC2C2C2C2);
        tick();
        idle_inputs();
        drive(2, 2'd0, 32'hC3C3C3C3);
        grant[2] = 1'b1;
        tick();
        idle_inputs();
        check("t3_head", data_out[95:64], 32'hC3C3C3C3);
        tick();

        // 4: drops, single and simultaneous
        drive(3, 2'd3, 32'hD4D4D4D4);
        tick();
        idle_inputs();
        check("t4_drop1", drop_count, 16'd1);
        check("t4_noreq", req[3], 1'b0);
        drive(0, 2'd3, 32'h11111111);
        drive(3, 2'd3, 32'h33333333);
        tick();
        idle_inputs();
        check("t4_drop2", drop_count, 16'd3);

        // 5: stream through port 0 with grant held, crossing the pointer wrap
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            drive(0, 2'(k % 3), 32'hE0E0E000 + k);
            grant[0] = 1'b1;
            tick();
            check("t5_occ", occupancy[OW-1:0], 1);
        end
        idle_inputs();
        grant[0] = 1'b1;
        tick();
        idle_inputs();

        // random traffic on all ports
        for (int k = 0; k < 300; k++) begin
            in_valid = N'($urandom);
            in_dest  = (N*DESTW)'($urandom);
            for (int p = 0; p < N; p++) in_data[p*DW +: DW] = $urandom;
            grant = N'($urandom);
            tick();
        end
        idle_inputs();

        // 6: asynchronous reset with queued entries
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            drive(0, 2'd1, 32'hDEADBEEF);
            drive(1, 2'd2, 32'hCAFEBABE);
            tick();
        end
        idle_inputs();
        tick();
        #3 rst = 1'b0;
        #1;
        check("t6_req", req, 0);
        check("t6_dest", dest, 0);
        check("t6_data", data_out, 0);
        check("t6_occ", occupancy, 0);
        check("t6_drops", drop_count, 0);
        check("t6_ready", in_ready, 4'b1111);
        for (int p = 0; p < N; p++) sb[p].delete();
        mdrop = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        drive(1, 2'd0, 32'h12345678);
        tick();
        idle_inputs();
        check("t6_fresh", data_out[63:32], 32'h12345678);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
